rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Sequences the single write port of the 32x32 GPR file between two writers: the pipeline writeback stage and the multi-cycle mul/div unit.
- Keeps a 31-bit scoreboard of registers with an outstanding mul/div result, and flags read/write hazards to the issue stage.
- Bounds mul/div starvation by forcing a one-cycle pipeline writeback stall.

Parameters:
- STARVE_LIMIT, 4: consecutive blocked mul/div cycles before a forced grant; legal range 1..15.
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wb_we  in  1  pipeline writeback request
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- wb_hold  out  1  pipeline write not accepted this cycle; stage must hold wb_* stable
- md_valid  in  1  mul/div result ready
- md_rd  in  5  mul/div destination register
- md_data  in  32  mul/div result
- md_ack  out  1  mul/div result committed this cycle
- md_issue  in  1  mul/div operation issued this cycle
- md_issue_rd  in  5  destination register of the issued operation
- q_rs  in  5  issue-stage source register 1
- q_rt  in  5  issue-stage source register 2
- q_rd  in  5  issue-stage destination register
- issue_stall  out  1  q_rs, q_rt or q_rd is busy in the scoreboard
- rf_we  out  1  to register file RegWrite
- rf_waddr  out  5  to register file Write_register
- rf_wdata  out  32  to register file Write_data
- force_cnt  out  16  forced-grant event count (see Optional Feature)

Behaviour:
- Write path is combinational, zero latency: the register file samples rf_* on the next posedge clk.
- While reset is high: rf_we=0, wb_hold=0, md_ack=0, scoreboard cleared, state=IDLE, starvation counter=0, force_cnt=0.
- Any pending mul/div result is dropped on reset. The mul/div unit shares the same reset.
- A pipeline write "occupies" the port when wb_we=1 and wb_rd!=0. Writes to $0 never occupy the port.
- FSM states:
  - IDLE: no mul/div result waiting.
  - WAIT: md_valid=1 and blocked by the pipeline.
  - FORCE: mul/div has priority.
- IDLE/WAIT, port not occupied, md_valid=1:
  - rf_we=(md_rd!=0), rf_waddr=md_rd, rf_wdata=md_data, md_ack=1.
  - Next state IDLE; counter cleared.
- IDLE/WAIT, port occupied:
  - Pipeline write passes through: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data, md_ack=0, wb_hold=0.
  - If md_valid=1: counter increments and state becomes WAIT.
  - If the counter reaches STARVE_LIMIT: next state is FORCE.
- FORCE:
  - Mul/div result is committed and md_ack=1.
  - wb_hold=1 if the port is occupied; the held pipeline write is accepted next cycle.
  - Next state IDLE; counter cleared.
- md_valid must stay high with stable md_rd/md_data until md_ack. Dropping md_valid while in WAIT returns the FSM to IDLE and clears the counter.
- md_ack is never asserted without md_valid.
- Scoreboard, one bit per register 1..31:
  - Set on md_issue with md_issue_rd!=0; an issue to $0 is ignored.
  - Cleared on the cycle md_ack=1 for md_rd.
  - Same-cycle set and clear of the same register: set wins, because a new operation is outstanding.
  - Setting an already-busy bit leaves it set.
- issue_stall is combinational: the OR of the busy bits for q_rs, q_rt and q_rd. Register $0 is never busy.
- Write-after-write ordering: the issue stage stalls on a busy q_rd, so the scheduler never reorders writes to one register.

Optional Feature:
- Macro RF_WB_FORCE_COUNT_EN.
- Defined: force_cnt increments once per cycle spent in FORCE and saturates at 0xFFFF; it is cleared by reset.
- Undefined: force_cnt is tied to 0 and no counter logic exists.
- Scheduling behaviour is identical in both builds.

Test Plan:
- No conflict:
  - Stimulus: wb_we=0, md_valid=1, md_rd=8, md_data=0x12345678.
  - Response: same cycle rf_we=1, rf_waddr=8, rf_wdata=0x12345678, md_ack=1; scoreboard bit 8 cleared next cycle.
- Pipeline wins:
  - Stimulus: wb_we=1, wb_rd=9, wb_data=0xA5A5A5A5, together with md_valid=1, md_rd=10.
  - Response: rf_waddr=9, md_ack=0; when wb_we drops the next cycle, rf_waddr=10 and md_ack=1.
- Starvation:
  - Stimulus: wb_we=1 every cycle to rd=3, md_valid=1 to rd=4, STARVE_LIMIT=4.
  - Response: md_ack=0 for 4 cycles; 5th cycle wb_hold=1, rf_waddr=4, md_ack=1; next cycle rf_waddr=3, wb_hold=0; force_cnt=1 when the macro is defined.
- Scoreboard hazard:
  - Stimulus: md_issue=1, md_issue_rd=5, then q_rs=5.
  - Response: issue_stall=1 until the md_ack cycle for rd=5; then issue_stall=0. With q_rs=0, issue_stall=0 always.
- Set-wins and $0:
  - Stimulus: md_ack for rd=7 in the same cycle as md_issue_rd=7; separately an md commit with md_rd=0.
  - Response: bit 7 remains set; the rd=0 commit gives md_ack=1 and rf_we=0.
- Reset mid-WAIT:
  - Stimulus: assert reset while in WAIT with scoreboard bits 4 and 5 set.
  - Response: immediately rf_we=0, md_ack=0, issue_stall=0 for all queries; after release, state is IDLE and the counter is 0.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
//   Arbitrates the single GPR-file write port between the pipeline writeback
//   stage and the multi-cycle mul/div unit. It also keeps a scoreboard of
//   registers that have an outstanding mul/div result, and raises a hazard
//   stall to the issue stage when a queried register is busy.
//
//   Write path is combinational: the register file samples rf_* on the next
//   posedge clk. A mul/div result that has been blocked for STARVE_LIMIT
//   consecutive cycles is forced in. To do that, the pipeline write is held
//   for one cycle.
//
//   Optional build macro: RF_WB_FORCE_COUNT_EN
//     When it is defined, force_cnt counts the cycles spent in FORCE and
//     saturates at 0xFFFF. When it is undefined, force_cnt is tied to 0.
//
//   Ports
//     clk, reset        clock, asynchronous active-high reset
//     wb_we/rd/data     pipeline writeback request
//     wb_hold           pipeline write not accepted; hold wb_* stable
//     md_valid/rd/data  mul/div result, held stable until md_ack
//     md_ack            mul/div result committed this cycle
//     md_issue/_rd      mul/div operation issued (sets a scoreboard bit)
//     q_rs/q_rt/q_rd    issue-stage register queries
//     issue_stall       a queried register is busy
//     rf_we/waddr/wdata register file write port
//     force_cnt         forced-grant event count
module rf_wb_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_hold,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ack,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    input  logic [4:0]  q_rs,
    input  logic [4:0]  q_rt,
    input  logic [4:0]  q_rd,
    output logic        issue_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [15:0] force_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [31:1]      busy, busy_n;
    logic             occupied;
    logic             set_en, clr_en;

    // Writes to $0 never claim the port.
    assign occupied = wb_we && (wb_rd != 5'd0);
    assign cnt_inc  = cnt + 1'b1;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
        md_ack   = 1'b0;
        wb_hold  = 1'b0;
        state_n  = IDLE;
        cnt_n    = '0;
        if (reset) begin
            // Outputs are forced quiet while reset is high. The registers
            // are cleared asynchronously.
        end else if (state == FORCE) begin
            // mul/div has priority. md_ack is qualified by md_valid so it
            // can never fire without a result present.
            if (md_valid) begin
                md_ack   = 1'b1;
                rf_we    = (md_rd != 5'd0);
                rf_waddr = md_rd;
                rf_wdata = md_data;
            end
            wb_hold = occupied;
        end else if (occupied) begin
            rf_we = 1'b1;
            if (md_valid) begin
                cnt_n   = cnt_inc;
                state_n = (cnt_inc >= CNT_W'(STARVE_LIMIT)) ? FORCE : WAIT;
            end
        end else if (md_valid) begin
            md_ack   = 1'b1;
            rf_we    = (md_rd != 5'd0);
            rf_waddr = md_rd;
            rf_wdata = md_data;
        end
    end

    // Scoreboard update. When a register is set and cleared in the same
    // cycle, set wins, because a newer operation is then outstanding.
    assign set_en = md_issue && (md_issue_rd != 5'd0);
    assign clr_en = md_ack && (md_rd != 5'd0);

    always_comb begin
        busy_n = busy;
        for (int i = 1; i < 32; i++) begin
            busy_n[i] = (busy[i] && !(clr_en && md_rd == 5'(i)))
                      || (set_en && md_issue_rd == 5'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
        end
    end

    // Bit 0 stands for $0, which is never busy.
    logic [31:0] busy_v;
    assign busy_v      = {busy, 1'b0};
    assign issue_stall = busy_v[q_rs] | busy_v[q_rt] | busy_v[q_rd];

`ifdef RF_WB_FORCE_COUNT_EN
    logic [15:0] fcnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fcnt <= '0;
        else if (state == FORCE && fcnt != 16'hFFFF)
            fcnt <= fcnt + 16'd1;
    end
    assign force_cnt = fcnt;
`else
    assign force_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_hold;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ack;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic [4:0]  q_rs, q_rt, q_rd;
    logic        issue_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] force_cnt;

    int total = 0;
    int bad   = 0;

`ifdef RF_WB_FORCE_COUNT_EN
    localparam logic [15:0] FC1 = 16'd1;
`else
    localparam logic [15:0] FC1 = 16'd0;
`endif

    rf_wb_scheduler #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_hold(wb_hold),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ack(md_ack),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd),
        .q_rs(q_rs), .q_rt(q_rt), .q_rd(q_rd), .issue_stall(issue_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .force_cnt(force_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge. Inputs are then changed 1 time unit after the
    // posedge, and checks run 2 time units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h44;
        md_issue = 1'b0; md_issue_rd = 5'd0;
        q_rs = 5'd0; q_rt = 5'd0; q_rd = 5'd0;
        settle();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_md_ack", md_ack, 0);
        chk("rst_wb_hold", wb_hold, 0);
        chk("rst_force_cnt", force_cnt, 0);
        tick();
        wb_we = 1'b0; md_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // No conflict: rd 8 is busy, then its result commits at once.
        md_issue = 1'b1; md_issue_rd = 5'd8;
        tick();
        md_issue = 1'b0; q_rs = 5'd8;
        settle();
        chk("nc_stall_before", issue_stall, 1);
        md_valid = 1'b1; md_rd = 5'd8; md_data = 32'h12345678;
        settle();
        chk("nc_rf_we", rf_we, 1);
        chk("nc_waddr", rf_waddr, 8);
        chk("nc_wdata", rf_wdata, 32'h12345678);
        chk("nc_md_ack", md_ack, 1);
        chk("nc_wb_hold", wb_hold, 0);
        chk("nc_stall_same_cycle", issue_stall, 1);
        tick();
        md_valid = 1'b0;
        settle();
        chk("nc_stall_cleared", issue_stall, 0);
        q_rs = 5'd0;

        // Pipeline wins; mul/div commits on the following cycle.
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5A5A5A5;
        md_valid = 1'b1; md_rd = 5'd10; md_data = 32'hDEADBEEF;
        settle();
        chk("pw_waddr", rf_waddr, 9);
        chk("pw_wdata", rf_wdata, 32'hA5A5A5A5);
        chk("pw_rf_we", rf_we, 1);
        chk("pw_md_ack", md_ack, 0);
        tick();
        wb_we = 1'b0;
        settle();
        chk("pw2_waddr", rf_waddr, 10);
        chk("pw2_wdata", rf_wdata, 32'hDEADBEEF);
        chk("pw2_md_ack", md_ack, 1);
        tick();
        md_valid = 1'b0;

        // Starvation: four blocked cycles, then a forced grant.
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h44;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("sv_blocked_ack%0d", i), md_ack, 0);
            chk($sformatf("sv_blocked_waddr%0d", i), rf_waddr, 3);
            chk($sformatf("sv_blocked_hold%0d", i), wb_hold, 0);
            tick();
        end
        settle();
        chk("sv_force_hold", wb_hold, 1);
        chk("sv_force_waddr", rf_waddr, 4);
        chk("sv_force_wdata", rf_wdata, 32'h44);
        chk("sv_force_ack", md_ack, 1);
        tick();
        md_valid = 1'b0;
        settle();
        chk("sv_after_waddr", rf_waddr, 3);
        chk("sv_after_we", rf_we, 1);
        chk("sv_after_hold", wb_hold, 0);
        chk("sv_force_cnt", force_cnt, FC1);
        tick();
        wb_we = 1'b0;

        // Scoreboard hazard on rd 5.
        md_issue = 1'b1; md_issue_rd = 5'd5;
        tick();
        md_issue = 1'b0; q_rs = 5'd5;
        settle();
        chk("hz_stall1", issue_stall, 1);
        tick();
        settle();
        chk("hz_stall2", issue_stall, 1);
        md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h55;
        settle();
        chk("hz_ack", md_ack, 1);
        chk("hz_stall_ack_cycle", issue_stall, 1);
        tick();
        md_valid = 1'b0;
        settle();
        chk("hz_stall_clear", issue_stall, 0);
        q_rs = 5'd0;

        // Set wins over a same-cycle clear, and a commit to $0.
        md_issue = 1'b1; md_issue_rd = 5'd7;
        tick();
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77;
        md_issue = 1'b1; md_issue_rd = 5'd7;
        settle();
        chk("sw_ack", md_ack, 1);
        tick();
        md_valid = 1'b0; md_issue = 1'b0;
        q_rd = 5'd7;
        settle();
        chk("sw_bit7_set_rd", issue_stall, 1);
        q_rd = 5'd0; q_rt = 5'd7;
        settle();
        chk("sw_bit7_set_rt", issue_stall, 1);
        q_rt = 5'd0;
        settle();
        chk("sw_zero_query", issue_stall, 0);
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'hFF;
        settle();
        chk("z_ack", md_ack, 1);
        chk("z_rf_we", rf_we, 0);
        tick();
        md_rd = 5'd7; md_data = 32'h77;
        tick();
        md_valid = 1'b0; q_rd = 5'd7;
        settle();
        chk("sw_bit7_cleared", issue_stall, 0);
        q_rd = 5'd0;

        // Reset asserted mid-WAIT with bits 4 and 5 busy.
        md_issue = 1'b1; md_issue_rd = 5'd4;
        tick();
        md_issue_rd = 5'd5;
        tick();
        md_issue = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h44;
        q_rs = 5'd4; q_rt = 5'd5;
        settle();
        chk("rw_pre_stall", issue_stall, 1);
        tick();
        tick();
        reset = 1'b1;
        settle();
        chk("rw_rf_we", rf_we, 0);
        chk("rw_md_ack", md_ack, 0);
        chk("rw_stall", issue_stall, 0);
        chk("rw_force_cnt", force_cnt, 0);
        md_valid = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        chk("rw_post_stall", issue_stall, 0);
        chk("rw_post_we", rf_we, 1);
        q_rs = 5'd0; q_rt = 5'd0;
        md_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("rw_blocked_ack%0d", i), md_ack, 0);
            tick();
        end
        settle();
        chk("rw_force_ack", md_ack, 1);
        chk("rw_force_hold", wb_hold, 1);
        tick();
        md_valid = 1'b0;
        settle();
        chk("rw_force_cnt_after", force_cnt, FC1);
        tick();
        wb_we = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
